onehot_tracker: RTL
===================

ONEHOT_TRACKER -- requirements
Module: onehot_tracker

Interface
REQ-001 SHALL have parameter REV_W, default 8: width of the signed revolution counter.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port onehot  input  8: position code from the upstream one-hot up/down counter; bit i set = position i.
REQ-005 SHALL have port err_clr  input  1: clears the sticky error flag.
REQ-006 SHALL have port pos  output  3: binary index of the last legal code sampled.
REQ-007 SHALL have port valid  output  1: high when the last sample had exactly one bit set.
REQ-008 SHALL have port step_up  output  1: one-cycle pulse, position advanced by +1 (mod 8).
REQ-009 SHALL have port step_dn  output  1: one-cycle pulse, position moved by -1 (mod 8).
REQ-010 SHALL have port wrap_up  output  1: one-cycle pulse, transition 7 -> 0.
REQ-011 SHALL have port wrap_dn  output  1: one-cycle pulse, transition 0 -> 7.
REQ-012 SHALL have port rev_count  output  REV_W: signed two's-complement net revolutions.
REQ-013 SHALL have port err  output  1: sticky flag, illegal code or jump seen.

Function
REQ-014 SHALL sample onehot at every rising clk edge; all outputs are registered, so they reflect the sample taken at the previous edge (latency 1 cycle).
REQ-015 SHALL implement two states: IDLE (no legal reference position held) and TRACK (reference position held in pos).
REQ-016 Legal code: exactly one bit of onehot set; illegal code: zero bits or two or more bits set.
REQ-017 IDLE + legal code: load pos with the index, valid=1, go to TRACK; no step/wrap pulse, rev_count unchanged.
REQ-018 IDLE + illegal code: stay IDLE, valid=0, err set, pos held.
REQ-019 TRACK + legal code equal to pos: stay TRACK, no pulses.
REQ-020 TRACK + legal code equal to pos+1 mod 8: update pos, assert step_up; if pos was 7, also assert wrap_up and increment rev_count.
REQ-021 TRACK + legal code equal to pos-1 mod 8: update pos, assert step_dn; if pos was 0, also assert wrap_dn and decrement rev_count.
REQ-022 TRACK + legal code at distance 2..6 (jump): set err, load pos with the new index (resync), stay TRACK, no step/wrap pulse, rev_count unchanged.
REQ-023 TRACK + illegal code: valid=0, err set, pos held, go to IDLE, no pulses.
REQ-024 step_up and step_dn SHALL never be high together; wrap_up implies step_up, and wrap_dn implies step_dn, in the same cycle.
REQ-025 rev_count SHALL saturate at +(2^(REV_W-1))-1 and -(2^(REV_W-1)); a wrap at the limit still pulses wrap_up/wrap_dn but leaves the count unchanged.
REQ-026 err_clr=1 SHALL clear err at the next edge; if an error event occurs in the same cycle, err stays 1 (set wins).
REQ-027 valid SHALL be 1 after any legal sample and 0 after any illegal sample, regardless of state.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE, pos=0, valid=0, all pulses=0, rev_count=0, err=0, overriding all other inputs.
REQ-029 Reset asserted mid-operation SHALL discard the held position; the first legal sample after reset reloads pos without a step pulse.

Verification
REQ-030 Reset, then onehot=0x01 for 1 cycle, then 0x02, 0x04 -> pos 0,1,2; step_up pulses on the 2nd and 3rd samples only; err=0.
REQ-031 From pos=7 (0x80), apply 0x01 -> step_up=1, wrap_up=1, rev_count=1; then apply 0x80 -> step_dn=1, wrap_dn=1, rev_count=0.
REQ-032 From pos=2, apply 0x20 -> err=1, pos=5, no step pulse; then 0x40 -> step_up=1; assert err_clr -> err=0 next cycle.
REQ-033 From TRACK, apply 0x00, then 0x11 -> valid=0 both cycles, err=1, IDLE; then 0x08 -> pos=3, valid=1, no step pulse.
REQ-034 With REV_W=8, 127 up-revolutions -> rev_count=127; one more 7->0 -> wrap_up=1, rev_count stays 127; symmetric check at -128.
REQ-035 Apply rst for 1 cycle mid-sequence at pos=4, rev_count=3 -> all outputs zero next cycle; then 0x10 -> pos=4, no pulse, rev_count=0.

Source files
------------

// File: rtl/onehot_tracker.sv
// Tracks the position reported by an 8-bit one-hot up/down counter, emitting
// step/wrap pulses, a saturating signed revolution count and a sticky error flag.
module onehot_tracker #(
    parameter int unsigned REV_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              onehot,
    input  logic                    err_clr,
    output logic [2:0]              pos,
    output logic                    valid,
    output logic                    step_up,
    output logic                    step_dn,
    output logic                    wrap_up,
    output logic                    wrap_dn,
    output logic signed [REV_W-1:0] rev_count,
    output logic                    err
);

    localparam int unsigned N_POS = 8;
    localparam int unsigned POS_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic signed [REV_W-1:0] REV_MAX = {1'b0, {(REV_W-1){1'b1}}};
    localparam logic signed [REV_W-1:0] REV_MIN = {1'b1, {(REV_W-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t                  state_q;
    logic [POS_W-1:0]        pos_q;
    logic                    valid_q;
    logic                    step_up_q;
    logic                    step_dn_q;
    logic                    wrap_up_q;
    logic                    wrap_dn_q;
    logic signed [REV_W-1:0] rev_q;
    logic                    err_q;

    logic [CNT_W-1:0]        ones;
    logic [POS_W-1:0]        idx;
    logic                    legal;
    logic [POS_W-1:0]        delta;
    logic                    move_up;
    logic                    move_dn;
    logic                    jump;
    logic                    err_event;
    logic signed [REV_W-1:0] rev_inc_d;
    logic signed [REV_W-1:0] rev_dec_d;

    // Population count and index of the sampled code.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < N_POS; i++) begin
            if (onehot[i]) begin
                ones = ones + CNT_W'(1);
                idx  = POS_W'(i);
            end
        end
    end

    // Classify the move relative to the held position (mod-8 distance).
    always_comb begin
        legal     = (ones == CNT_W'(1));
        delta     = idx - pos_q;
        move_up   = (state_q == TRACK) && legal && (delta == POS_W'(1));
        move_dn   = (state_q == TRACK) && legal && (delta == POS_W'(7));
        jump      = (state_q == TRACK) && legal && !move_up && !move_dn
                    && (delta != POS_W'(0));
        err_event = !legal || jump;
        rev_inc_d = (rev_q == REV_MAX) ? rev_q : rev_q + REV_W'(1);
        rev_dec_d = (rev_q == REV_MIN) ? rev_q : rev_q - REV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            valid_q   <= 1'b0;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
            rev_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
            valid_q   <= legal;

            // Set has priority over clear.
            if (err_event) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (legal) begin
                        pos_q   <= idx;
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    if (!legal) begin
                        state_q <= IDLE;
                    end else if (move_up) begin
                        pos_q     <= idx;
                        step_up_q <= 1'b1;
                        if (pos_q == POS_W'(7)) begin
                            wrap_up_q <= 1'b1;
                            rev_q     <= rev_inc_d;
                        end
                    end else if (move_dn) begin
                        pos_q     <= idx;
                        step_dn_q <= 1'b1;
                        if (pos_q == POS_W'(0)) begin
                            wrap_dn_q <= 1'b1;
                            rev_q     <= rev_dec_d;
                        end
                    end else if (jump) begin
                        pos_q <= idx;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pos       = pos_q;
    assign valid     = valid_q;
    assign step_up   = step_up_q;
    assign step_dn   = step_dn_q;
    assign wrap_up   = wrap_up_q;
    assign wrap_dn   = wrap_dn_q;
    assign rev_count = rev_q;
    assign err       = err_q;

endmodule
